// File: rtl/id_stage_pkg.sv
// id_stage_pkg: decode-stage input type shared with the fetch stage.
`ifndef ID_STAGE_PKG_SV
`define ID_STAGE_PKG_SV

package id_stage_pkg;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc4;
    } id_stage_in_t;

endpackage

`endif

// File: rtl/if_stage_pkg.sv
// if_stage_pkg: fetch-stage types and constants.
// IF_FETCH_BUF_EN selects the buffered build (capacity 2) versus the
// unbuffered build (capacity 1).
`ifndef IF_STAGE_PKG_SV
`define IF_STAGE_PKG_SV

package if_stage_pkg;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } if_entry_t;

`ifdef IF_FETCH_BUF_EN
    localparam int unsigned IF_CAPACITY = 2;
`else
    localparam int unsigned IF_CAPACITY = 1;
`endif

    localparam logic [31:0] IF_PC_STEP = 32'd4;

    // Expand a fetched entry into the decode-stage bundle; pc4 wraps mod 2^32.
    function automatic id_stage_pkg::id_stage_in_t to_id_in(if_entry_t e);
        id_stage_pkg::id_stage_in_t r;
        r.inst = e.inst;
        r.pc   = e.pc;
        r.pc4  = e.pc + IF_PC_STEP;
        return r;
    endfunction

endpackage

`endif

// File: rtl/if_stage_fetch_fifo.sv
// fetch_fifo: 2-entry synchronous FIFO of fetched entries with flush.
// Only instantiated when IF_FETCH_BUF_EN is defined.
module fetch_fifo
    import if_stage_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      flush,
    input  logic      push,
    input  if_entry_t push_data,
    input  logic      pop,
    output if_entry_t pop_data,
    output logic      full,
    output logic      empty
);

    if_entry_t  mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] cnt_q;
    logic       push_ok;
    logic       pop_ok;

    assign full     = (cnt_q == 2'd2);
    assign empty    = (cnt_q == 2'd0);
    assign pop_data = mem_q[rd_ptr_q];
    assign pop_ok   = pop && !empty;
    assign push_ok  = push && (!full || pop_ok);

    // Storage, pointers and occupancy; flush empties the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= '0;
        end else if (flush) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_ok) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q <= cnt_q + 2'(push_ok) - 2'(pop_ok);
        end
    end

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch. Owns the PC, issues word fetches over a
// req/gnt/rvalid handshake and presents {inst, pc, pc4} to decode.
// Define IF_FETCH_BUF_EN for the 2-entry fetch buffer (full throughput).
module if_stage
    import id_stage_pkg::*;
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst_n,
    output logic         imem_req,
    output logic [31:0]  imem_addr,
    input  logic         imem_gnt,
    input  logic         imem_rvalid,
    input  logic [31:0]  imem_rdata,
    input  logic         redirect,
    input  logic [31:0]  redirect_pc,
    output logic         out_valid,
    input  logic         out_ready,
    output id_stage_in_t out
);

    logic [31:0] pc_q;
    logic [1:0]  outstanding_q;
    logic [1:0]  outstanding_d;
    logic [1:0]  discard_q;
    logic [1:0]  buffered;
    logic [2:0]  occupancy;
    logic        req_raw;
    logic        accept;
    logic        resp_valid;
    logic        tag_push;
    logic        load_en;
    logic [31:0] tag_head;
    if_entry_t   resp_entry;
    if_entry_t   load_entry;

    // An output entry that will be consumed this cycle does not occupy a slot.
    assign occupancy  = 3'(outstanding_q) + 3'(buffered) + 3'(out_valid && !out_ready);
    assign req_raw    = rst_n && (occupancy < 3'(IF_CAPACITY));
    assign imem_req   = req_raw && !redirect;
    assign imem_addr  = pc_q;
    // A grant landing in the redirect cycle is still counted so its response is discarded.
    assign accept     = imem_gnt && req_raw;
    assign tag_push   = accept && !redirect;
    assign resp_valid = imem_rvalid && (discard_q == 2'd0) && !redirect;
    assign resp_entry = '{inst: imem_rdata, pc: tag_head};

    assign outstanding_d = outstanding_q + 2'(accept) - 2'(imem_rvalid);

    // Fetch PC: redirect wins, otherwise advance on every accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else if (redirect) begin
            pc_q <= redirect_pc & ~32'h3;
        end else if (accept) begin
            pc_q <= pc_q + IF_PC_STEP;
        end
    end

    // Outstanding and discard counters; on redirect every in-flight response becomes stale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            if (redirect) begin
                discard_q <= outstanding_d;
            end else if (imem_rvalid && (discard_q != 2'd0)) begin
                discard_q <= discard_q - 2'd1;
            end
        end
    end

`ifdef IF_FETCH_BUF_EN
    logic [31:0] tag_q [2];
    logic [1:0]  tag_cnt_q;

    assign tag_head = tag_q[0];

    // Tag FIFO of live (non-discarded) request PCs, head at index 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q[0]  <= '0;
            tag_q[1]  <= '0;
            tag_cnt_q <= '0;
        end else if (redirect) begin
            tag_cnt_q <= '0;
        end else begin
            case ({tag_push, resp_valid})
                2'b10: begin
                    tag_q[tag_cnt_q[0]] <= pc_q;
                    tag_cnt_q           <= tag_cnt_q + 2'd1;
                end
                2'b01: begin
                    tag_q[0]  <= tag_q[1];
                    tag_cnt_q <= tag_cnt_q - 2'd1;
                end
                2'b11: begin
                    if (tag_cnt_q == 2'd1) begin
                        tag_q[0] <= pc_q;
                    end else begin
                        tag_q[0] <= tag_q[1];
                        tag_q[1] <= pc_q;
                    end
                end
                default: ;
            endcase
        end
    end

    logic      out_free;
    logic      fifo_push;
    logic      fifo_pop;
    logic      fifo_full;
    logic      fifo_empty;
    if_entry_t fifo_rdata;

    // Responses bypass the FIFO only when it is empty and the output slot frees up.
    assign out_free  = !out_valid || out_ready;
    assign fifo_pop  = out_free && !fifo_empty && !redirect;
    assign fifo_push = resp_valid && !(out_free && fifo_empty);
    assign buffered  = {fifo_full, !fifo_full && !fifo_empty};

    fetch_fifo u_fetch_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect),
        .push      (fifo_push),
        .push_data (resp_entry),
        .pop       (fifo_pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Output load source: buffered entry first (ordering), else the live response.
    always_comb begin
        load_en    = 1'b0;
        load_entry = resp_entry;
        if (out_free && !fifo_empty) begin
            load_en    = 1'b1;
            load_entry = fifo_rdata;
        end else if (out_free && resp_valid) begin
            load_en = 1'b1;
        end
    end
`else
    logic [31:0] tag_q;

    assign tag_head = tag_q;

    // Single tag register: at most one request is ever in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q <= '0;
        end else if (tag_push) begin
            tag_q <= pc_q;
        end
    end

    // Issue already guarantees the output slot is free when a response lands.
    assign buffered   = '0;
    assign load_en    = resp_valid;
    assign load_entry = resp_entry;
`endif

    // Registered output to decode; held while stalled, cleared by redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out       <= '0;
        end else if (redirect) begin
            out_valid <= 1'b0;
        end else if (load_en) begin
            out_valid <= 1'b1;
            out       <= to_id_in(load_entry);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed test of if_stage against a small in-order memory.
// Expectations adapt to IF_FETCH_BUF_EN where timing differs between builds.
module tb_if_stage;
    import id_stage_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
`ifdef IF_FETCH_BUF_EN
    localparam bit BUF = 1'b1;
`else
    localparam bit BUF = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         imem_req;
    logic [31:0]  imem_addr;
    logic         imem_gnt = 1'b0;
    logic         imem_rvalid = 1'b0;
    logic [31:0]  imem_rdata = '0;
    logic         redirect = 1'b0;
    logic [31:0]  redirect_pc = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    id_stage_in_t dut_out;

    logic gnt_en = 1'b0;
    logic resp_en = 1'b0;
    logic gnt_force = 1'b0;
    int   cyc = 0;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [31:0]  mem_addr_q [$];
    int           mem_cyc_q [$];
    logic [31:0]  req_log [$];
    id_stage_in_t got [$];
    int           got_cyc [$];

    always #5 clk = ~clk;

    if_stage #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out         (dut_out)
    );

    function automatic logic [31:0] inst_of(logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    function automatic id_stage_in_t got_at(int i);
        id_stage_in_t e;
        e = 'x;
        if (i < got.size()) e = got[i];
        return e;
    endfunction

    function automatic logic [31:0] req_at(int i);
        logic [31:0] a;
        a = 'x;
        if (i < req_log.size()) a = req_log[i];
        return a;
    endfunction

    function automatic logic [31:0] got_cyc_at(int i);
        logic [31:0] c;
        c = 'x;
        if (i < got_cyc.size()) c = 32'(got_cyc[i]);
        return c;
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One clock cycle: memory response, grant, sampling, then the edge.
    task automatic step();
        if (resp_en && mem_addr_q.size() > 0 && mem_cyc_q[0] < cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = inst_of(mem_addr_q[0]);
            void'(mem_addr_q.pop_front());
            void'(mem_cyc_q.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
        #1;
        imem_gnt = gnt_force | (gnt_en & imem_req);
        #1;
        if (imem_gnt && (imem_req || gnt_force)) begin
            mem_addr_q.push_back(imem_addr);
            mem_cyc_q.push_back(cyc);
            if (imem_req) req_log.push_back(imem_addr);
        end
        if (out_valid && out_ready) begin
            got.push_back(dut_out);
            got_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        out_ready   = 1'b0;
        gnt_en      = 1'b0;
        resp_en     = 1'b0;
        gnt_force   = 1'b0;
        mem_addr_q.delete();
        mem_cyc_q.delete();
        req_log.delete();
        got.delete();
        got_cyc.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        #2;
        // reset values
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", imem_addr, RST_PC);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_inst", dut_out.inst, 32'd0);
        check("rst_pc", dut_out.pc, 32'd0);
        check("rst_pc4", dut_out.pc4, 32'd0);
        do_reset();

        // streaming fetch from reset PC
        gnt_en = 1'b1; resp_en = 1'b1; out_ready = 1'b1;
        repeat (8) step();
        check("s_req0", req_at(0), 32'h0000_0000);
        check("s_req1", req_at(1), 32'h0000_0004);
        check("s_req2", req_at(2), 32'h0000_0008);
        check("s_pc0", got_at(0).pc, 32'h0000_0000);
        check("s_pc4_0", got_at(0).pc4, 32'h0000_0004);
        check("s_inst0", got_at(0).inst, 32'h1357_9BDF);
        check("s_pc1", got_at(1).pc, 32'h0000_0004);
        check("s_pc4_1", got_at(1).pc4, 32'h0000_0008);
        check("s_inst1", got_at(1).inst, 32'h1357_9BDB);
        check("s_pc2", got_at(2).pc, 32'h0000_0008);
        check("s_first_cyc", got_cyc_at(0), 32'd2);
        check("s_gap", got_cyc_at(1) - got_cyc_at(0), BUF ? 32'd1 : 32'd2);

        // asynchronous reset mid-stream
        check("mr_pre_valid", 32'(out_valid), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mr_valid", 32'(out_valid), 32'd0);
        check("mr_addr", imem_addr, RST_PC);
        check("mr_req", 32'(imem_req), 32'd0);
        do_reset();

        // back-pressure: decode stalled for 5 cycles with out_valid high
        gnt_en = 1'b1; resp_en = 1'b1; out_ready = 1'b0;
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_pc_hold", dut_out.pc, 32'h0000_0000);
            check("bp_inst_hold", dut_out.inst, 32'h1357_9BDF);
            if (i == 4) check("bp_req_low", 32'(imem_req), 32'd0);
            step();
        end
        out_ready = 1'b1;
        repeat (12) step();
        check("bp_release_cyc", got_cyc_at(0), 32'd7);
        for (int i = 0; i < 5; i++) begin
            check("bp_seq_pc", got_at(i).pc, 32'(4 * i));
            check("bp_seq_pc4", got_at(i).pc4, 32'(4 * i + 4));
        end
        do_reset();

        // redirect while fetches are outstanding and unanswered
        gnt_en = 1'b1; resp_en = 1'b0; out_ready = 1'b1;
        step();
        step();
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        req_log.delete(); got.delete(); got_cyc.delete();
        step();
        redirect = 1'b0; resp_en = 1'b1;
        check("ro_valid_cleared", 32'(out_valid), 32'd0);
        repeat (8) step();
        check("ro_req0", req_at(0), 32'h0000_0100);
        check("ro_req1", req_at(1), 32'h0000_0104);
        check("ro_pc0", got_at(0).pc, 32'h0000_0100);
        check("ro_pc4_0", got_at(0).pc4, 32'h0000_0104);
        check("ro_inst0", got_at(0).inst, 32'h1357_9ADF);
        check("ro_pc1", got_at(1).pc, 32'h0000_0104);
        do_reset();

        // redirect coinciding with a response (and a grant in the buffered build)
        gnt_en = 1'b1; resp_en = 1'b1; out_ready = 1'b1;
        repeat (BUF ? 4 : 3) step();
        req_log.delete(); got.delete(); got_cyc.delete();
        redirect = 1'b1; redirect_pc = 32'h0000_0200; gnt_force = BUF;
        #1;
        check("rc_req_low", 32'(imem_req), 32'd0);
        step();
        redirect = 1'b0; gnt_force = 1'b0;
        check("rc_valid_cleared", 32'(out_valid), 32'd0);
        repeat (6) step();
        check("rc_req0", req_at(0), 32'h0000_0200);
        check("rc_pc0", got_at(0).pc, 32'h0000_0200);
        check("rc_pc4_0", got_at(0).pc4, 32'h0000_0204);
        check("rc_inst0", got_at(0).inst, 32'h1357_99DF);
        check("rc_latency", got_cyc_at(0), BUF ? 32'd7 : 32'd6);
        do_reset();

        // PC wrap at the top of the address space
        gnt_en = 1'b1; resp_en = 1'b1; out_ready = 1'b1;
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        repeat (8) step();
        check("w_req0", req_at(0), 32'hFFFF_FFFC);
        check("w_req1", req_at(1), 32'h0000_0000);
        check("w_pc0", got_at(0).pc, 32'hFFFF_FFFC);
        check("w_pc4_0", got_at(0).pc4, 32'h0000_0000);
        check("w_inst0", got_at(0).inst, 32'hECA8_6423);
        check("w_pc1", got_at(1).pc, 32'h0000_0000);
        check("w_pc4_1", got_at(1).pc4, 32'h0000_0004);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
